// File: rtl/mux32_sel.sv
// 2-to-1 word mux built from gate-level bit slices; outO is combinational (0 cycles), outQ is registered (1 cycle).
// No flow control or backpressure. rst clears only the registered copy.

module mux32_bit (
  input  logic a,
  input  logic b,
  input  logic s,
  input  logic s_n,
  output logic o
);

  assign o = (a & s_n) | (b & s);

endmodule

module mux32_sel #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inS,
  output logic [WIDTH-1:0] outO,
  output logic [WIDTH-1:0] outQ
);

  // Inverted select is generated once and shared by every slice.
  logic sel_n;
  assign sel_n = ~inS;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    mux32_bit u_bit (
      .a   (inA[i]),
      .b   (inB[i]),
      .s   (inS),
      .s_n (sel_n),
      .o   (outO[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outQ <= '0;
    end else begin
      outQ <= outO;
    end
  end

endmodule

// File: tb/tb_mux32_sel.sv
// Directed bench for mux32_sel: combinational select, bit isolation, registered latency and reset.
module tb_mux32_sel;

  logic        clk;
  logic        rst;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        inS;
  logic [31:0] outO;
  logic [31:0] outQ;

  int compared = 0;
  int mismatched = 0;

  mux32_sel #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .inA  (inA),
    .inB  (inB),
    .inS  (inS),
    .outO (outO),
    .outQ (outQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] one_hot;

    rst = 1'b1;
    inA = '0;
    inB = '0;
    inS = 1'b0;

    inA = 32'h0000_0001; inB = 32'h8000_0000; inS = 1'b0; #10;
    check("comb_lsb_sel_a", outO, 32'h0000_0001);
    inS = 1'b1; #10;
    check("comb_msb_sel_b", outO, 32'h8000_0000);
    inA = 32'h8000_0000; inB = 32'h0000_0001; inS = 1'b0; #10;
    check("comb_msb_sel_a", outO, 32'h8000_0000);
    inS = 1'b1; #10;
    check("comb_lsb_sel_b", outO, 32'h0000_0001);

    for (int i = 0; i < 32; i++) begin
      one_hot = 32'h0000_0001 << i;
      inA = one_hot;
      inB = ~one_hot;
      inS = 1'b0; #2;
      check($sformatf("walk_a_%0d", i), outO, one_hot);
      inS = 1'b1; #2;
      check($sformatf("walk_b_%0d", i), outO, ~one_hot);
    end

    // Hold reset for two edges with non-zero inputs: outQ must be zero.
    inA = 32'hFFFF_FFFF; inB = 32'hFFFF_FFFF; inS = 1'b0;
    edge_step();
    edge_step();
    check("reset_outq", outQ, 32'h0000_0000);
    check("reset_outo_live", outO, 32'hFFFF_FFFF);

    rst = 1'b0;
    inA = 32'hDEAD_BEEF; inB = 32'h0000_0000; inS = 1'b0; #1;
    check("pre_edge_outq_zero", outQ, 32'h0000_0000);
    edge_step();
    check("reg_deadbeef", outQ, 32'hDEAD_BEEF);

    inB = 32'h1234_5678; inS = 1'b1; #1;
    check("comb_switch_b", outO, 32'h1234_5678);
    check("reg_hold_before_edge", outQ, 32'hDEAD_BEEF);
    edge_step();
    check("reg_follow_b", outQ, 32'h1234_5678);

    inS = 1'b0;
    edge_step();
    check("reg_back_to_a", outQ, 32'hDEAD_BEEF);

    rst = 1'b1;
    edge_step();
    check("midop_reset_outq", outQ, 32'h0000_0000);
    check("midop_reset_outo", outO, 32'hDEAD_BEEF);

    rst = 1'b0; #1;
    check("release_hold_zero", outQ, 32'h0000_0000);
    edge_step();
    check("release_recapture", outQ, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux32_sel.md
Name: mux32_sel

Overview:
- 32-bit, 2-to-1 word multiplexer for the single-cycle datapath.
- Use sites: ALU operand select, writeback select and PC-source select.
- Provides a purely combinational output plus a registered copy of the same output for pipelined or staged use.
- Built as WIDTH identical 1-bit gate-level mux slices (NOT/AND/OR) plus an output register bank.

Parameters:
- WIDTH, 32, data width in bits of inA, inB, outO and outQ.

Ports:
- clk  input  1  single system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset; affects outQ only.
- inA  input  WIDTH  data word selected when inS=0.
- inB  input  WIDTH  data word selected when inS=1.
- inS  input  1  select line.
- outO  output  WIDTH  combinational mux result.
- outQ  output  WIDTH  registered mux result.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- Combinational path:
  - outO = inA when inS=0; outO = inB when inS=1.
  - Each bit i is (inA[i] AND NOT inS) OR (inB[i] AND inS).
  - No clock dependency and no latency.
  - outO is valid within one evaluation delta of any input change.
  - outO does not depend on clk or rst; it is correct even when clk is not toggling.
- Bit order:
  - Bit-for-bit mapping, no reordering.
  - inA[31] feeds outO[31] only; inA[0] feeds outO[0] only; the same holds for inB.
- Select X/Z: outO is unspecified and is not checked.
- Registered path:
  - On rising clk with rst=1: outQ <= 0 (all bits).
  - On rising clk with rst=0: outQ <= the current outO value.
  - Latency is exactly 1 cycle from an input change to outQ.
  - outQ holds its value between edges.
- Power-up: outQ is undefined until the first reset edge. Assertions are disabled until reset has been applied once.
- Reset mid-operation:
  - rst asserted at edge N forces outQ=0 after edge N, regardless of inputs.
  - At the first edge with rst=0, outQ takes outO.
  - The combinational outO is unaffected throughout.
- Simultaneous events: input changes coincident with a clk edge are captured with standard non-blocking semantics, i.e. the pre-edge value is registered.
- Structure:
  - A 1-bit slice cell is replicated WIDTH times via generate.
  - ~NOT(inS) is computed once and fanned out to all slices.
  - No behavioural "?:" operator is used in the slice.

Test Plan:
- inA=32'h00000001, inB=32'h80000000, inS=0, wait 10 -> outO=32'h00000001.
- Same inA/inB, inS=1 -> outO=32'h80000000.
- inA=32'h80000000, inB=32'h00000001, inS=0 -> outO=32'h80000000; with inS=1 -> outO=32'h00000001 (checks MSB/LSB isolation, no bit reversal).
- Walking-one over inA with inB=~inA, toggling inS, for all 32 positions -> outO equals the selected word exactly.
- Registered path: assert rst for 2 cycles -> outQ=0. Release rst with inA=32'hDEADBEEF, inS=0 -> outQ=32'hDEADBEEF one edge later. Switch to inS=1 with inB=32'h12345678 -> outQ follows after exactly one edge.
- Mid-operation reset: with outQ=32'hDEADBEEF, raise rst for one edge -> outQ=0 while outO stays 32'hDEADBEEF. Drop rst -> outQ=32'hDEADBEEF at the next edge.
